// File: rtl/wired_refill_arbiter_pkg.sv
// Shared types and constants for the refill arbiter slice.
package wired0_defines;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_RESP
    } refill_arb_state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'd2;
    localparam int unsigned LINE_BEATS = 4;

    typedef struct packed {
        logic [31:0] paddr;
        logic [1:0]  size;
        logic        uncached;
    } refill_req_t;

    // Sizes 0 and 1 behave like 2, so only 3 selects a doubleword.
    function automatic logic is_dword(input logic [1:0] size);
        return size == 2'd3;
    endfunction

    function automatic logic [31:0] ar_addr_mask(input refill_req_t req);
        if (!req.uncached)          return 32'hFFFF_FFF0;
        else if (is_dword(req.size)) return 32'hFFFF_FFF8;
        else                        return 32'hFFFF_FFFC;
    endfunction

    function automatic logic [7:0] ar_len_of(input refill_req_t req);
        if (!req.uncached)          return 8'(LINE_BEATS - 1);
        else if (is_dword(req.size)) return 8'd1;
        else                        return 8'd0;
    endfunction

endpackage

// File: rtl/wired_refill_arbiter_if.sv
// Request/response, refill and AXI read-channel bundle of the refill arbiter.
interface wired_refill_arbiter_if;
    logic [1:0]        req_valid_i;
    logic [1:0][31:0]  req_paddr_i;
    logic [1:0][1:0]   req_size_i;
    logic [1:0]        req_uncached_i;
    logic [1:0]        req_ready_o;
    logic [63:0]       resp_rdata_o;
    logic              resp_err_o;
    logic              refill_valid_o;
    logic              refill_port_o;
    logic [31:0]       refill_addr_o;
    logic [127:0]      refill_data_o;
    logic              ar_valid_o;
    logic              ar_ready_i;
    logic [31:0]       ar_addr_o;
    logic [7:0]        ar_len_o;
    logic [2:0]        ar_size_o;
    logic [1:0]        ar_burst_o;
    logic [3:0]        ar_id_o;
    logic              r_valid_i;
    logic              r_ready_o;
    logic [31:0]       r_data_i;
    logic              r_last_i;
    logic [1:0]        r_resp_i;

    modport master (
        input  req_valid_i, req_paddr_i, req_size_i, req_uncached_i,
        output req_ready_o, resp_rdata_o, resp_err_o,
        output refill_valid_o, refill_port_o, refill_addr_o, refill_data_o,
        output ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_id_o,
        input  ar_ready_i,
        input  r_valid_i, r_data_i, r_last_i, r_resp_i,
        output r_ready_o
    );

    modport slave (
        output req_valid_i, req_paddr_i, req_size_i, req_uncached_i,
        input  req_ready_o, resp_rdata_o, resp_err_o,
        input  refill_valid_o, refill_port_o, refill_addr_o, refill_data_o,
        input  ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_id_o,
        output ar_ready_i,
        output r_valid_i, r_data_i, r_last_i, r_resp_i,
        input  r_ready_o
    );
endinterface

// File: rtl/wired_refill_arbiter_rr.sv
// Two-requester one-hot grant; WIRED_ARB_FIXED_PRIO_EN makes port 1 always win ties.
module wired_rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       rr,
    output logic [1:0] gnt
);

`ifdef WIRED_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt = '0;
        if (req[1])      gnt = 2'b10;
        else if (req[0]) gnt = 2'b01;
    end
`else
    // rr names the port preferred when both request.
    always_comb begin
        gnt = req;
        if (req == 2'b11) gnt = rr ? 2'b10 : 2'b01;
    end
`endif

endmodule

// File: rtl/wired_refill_arbiter.sv
// Shares one AXI read channel between icache (port 0) and dcache (port 1).
// Build option: WIRED_ARB_FIXED_PRIO_EN (selected inside wired_rr_arbiter2).
module wired_refill_arbiter
    import wired0_defines::*;
#(
    parameter logic [3:0] AR_ID = 4'd0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wired_refill_arbiter_if.master bus
);

    refill_arb_state_e r_state, w_state_nxt;
    refill_req_t       r_req, w_sel_req;
    logic              r_grant;
    logic              r_rr;
    logic              r_err;
    logic [1:0]        r_beat_cnt;
    logic [3:0][31:0]  r_buf;
    logic [1:0]        w_gnt;
    logic [63:0]       w_rdata;

    wired_rr_arbiter2 u_arb (
        .req (bus.req_valid_i),
        .rr  (r_rr),
        .gnt (w_gnt)
    );

    always_comb begin
        w_sel_req.paddr    = w_gnt[1] ? bus.req_paddr_i[1]    : bus.req_paddr_i[0];
        w_sel_req.size     = w_gnt[1] ? bus.req_size_i[1]     : bus.req_size_i[0];
        w_sel_req.uncached = w_gnt[1] ? bus.req_uncached_i[1] : bus.req_uncached_i[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_req      <= '0;
            r_grant    <= 1'b0;
            r_rr       <= 1'b0;
            r_err      <= 1'b0;
            r_beat_cnt <= '0;
            r_buf      <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (|bus.req_valid_i) begin
                        r_grant    <= w_gnt[1];
                        r_req      <= w_sel_req;
                        r_beat_cnt <= '0;
                        r_err      <= 1'b0;
                    end
                end
                S_R: begin
                    // Extra beats past the fourth keep landing in the last slot.
                    if (bus.r_valid_i) begin
                        r_buf[r_beat_cnt] <= bus.r_data_i;
                        if (r_beat_cnt != 2'd3) r_beat_cnt <= r_beat_cnt + 2'd1;
                        if (bus.r_resp_i != 2'b00) r_err <= 1'b1;
                    end
                end
                S_RESP: r_rr <= ~r_grant;
                default: ;
            endcase
        end
    end

    always_comb begin
        if (!r_req.uncached)
            w_rdata = {r_buf[{r_req.paddr[3], 1'b1}], r_buf[{r_req.paddr[3], 1'b0}]};
        else if (is_dword(r_req.size))
            w_rdata = {r_buf[1], r_buf[0]};
        else if (r_req.paddr[2])
            w_rdata = {r_buf[0], 32'b0};
        else
            w_rdata = {32'b0, r_buf[0]};
    end

    // All outputs are qualified by state so idle/reset presents zeros.
    always_comb begin
        w_state_nxt        = r_state;
        bus.req_ready_o    = '0;
        bus.resp_rdata_o   = '0;
        bus.resp_err_o     = 1'b0;
        bus.refill_valid_o = 1'b0;
        bus.refill_port_o  = 1'b0;
        bus.refill_addr_o  = '0;
        bus.refill_data_o  = '0;
        bus.ar_valid_o     = 1'b0;
        bus.ar_addr_o      = '0;
        bus.ar_len_o       = '0;
        bus.ar_size_o      = '0;
        bus.ar_burst_o     = '0;
        bus.ar_id_o        = '0;
        bus.r_ready_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|bus.req_valid_i) w_state_nxt = S_AR;
            end
            S_AR: begin
                bus.ar_valid_o = 1'b1;
                bus.ar_addr_o  = r_req.paddr & ar_addr_mask(r_req);
                bus.ar_len_o   = ar_len_of(r_req);
                bus.ar_size_o  = SIZE_4B;
                bus.ar_burst_o = BURST_INCR;
                bus.ar_id_o    = AR_ID;
                if (bus.ar_ready_i) w_state_nxt = S_R;
            end
            S_R: begin
                bus.r_ready_o = 1'b1;
                if (bus.r_valid_i && bus.r_last_i) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                bus.req_ready_o    = r_grant ? 2'b10 : 2'b01;
                bus.resp_rdata_o   = w_rdata;
                bus.resp_err_o     = r_err;
                bus.refill_valid_o = !r_req.uncached && !r_err;
                bus.refill_port_o  = r_grant;
                bus.refill_addr_o  = {r_req.paddr[31:4], 4'b0};
                bus.refill_data_o  = r_buf;
                w_state_nxt        = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_wired_refill_arbiter.sv
// Directed self-checking bench for wired_refill_arbiter; honours WIRED_ARB_FIXED_PRIO_EN.
module tb_wired_refill_arbiter;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    wired_refill_arbiter_if bus ();

    wired_refill_arbiter #(.AR_ID(4'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_ar_valid"},     128'(bus.ar_valid_o),     128'(0));
        chk({tag, "_ar_addr"},      128'(bus.ar_addr_o),      128'(0));
        chk({tag, "_r_ready"},      128'(bus.r_ready_o),      128'(0));
        chk({tag, "_req_ready"},    128'(bus.req_ready_o),    128'(0));
        chk({tag, "_rdata"},        128'(bus.resp_rdata_o),   128'(0));
        chk({tag, "_resp_err"},     128'(bus.resp_err_o),     128'(0));
        chk({tag, "_refill_valid"}, 128'(bus.refill_valid_o), 128'(0));
        chk({tag, "_refill_data"},  bus.refill_data_o,        128'(0));
    endtask

    task automatic wait_ar(input int maxc);
        int n = 0;
        while (bus.ar_valid_o !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("ar_wait_timeout", 128'(bus.ar_valid_o), 128'(1));
    endtask

    // Entered at the negedge of the first S_AR cycle with ar_ready_i high;
    // returns at the negedge of the S_RESP cycle.
    task automatic txn(input int p, input logic [31:0] ea, input logic [7:0] el,
                       input int n, input logic [3:0][31:0] d, input int errbeat,
                       input logic [63:0] er, input logic rf);
        chk("ar_valid", 128'(bus.ar_valid_o), 128'(1));
        chk("ar_addr",  128'(bus.ar_addr_o),  128'(ea));
        chk("ar_len",   128'(bus.ar_len_o),   128'(el));
        chk("ar_size",  128'(bus.ar_size_o),  128'(3'd2));
        chk("ar_burst", 128'(bus.ar_burst_o), 128'(2'b01));
        chk("ar_id",    128'(bus.ar_id_o),    128'(4'd0));
        chk("r_ready_in_ar", 128'(bus.r_ready_o), 128'(0));
        @(negedge clk);
        chk("r_ready",        128'(bus.r_ready_o),  128'(1));
        chk("ar_valid_in_r",  128'(bus.ar_valid_o), 128'(0));
        for (int k = 0; k < n; k++) begin
            bus.r_valid_i = 1'b1;
            bus.r_data_i  = d[k];
            bus.r_last_i  = (k == n - 1);
            bus.r_resp_i  = (k == errbeat) ? 2'b10 : 2'b00;
            @(negedge clk);
        end
        bus.r_valid_i = 1'b0;
        bus.r_last_i  = 1'b0;
        bus.r_resp_i  = 2'b00;
        chk("req_ready",    128'(bus.req_ready_o),    128'(p == 1 ? 2'b10 : 2'b01));
        chk("rdata",        128'(bus.resp_rdata_o),   128'(er));
        chk("resp_err",     128'(bus.resp_err_o),     128'(errbeat >= 0));
        chk("refill_valid", 128'(bus.refill_valid_o), 128'(rf));
        if (rf) begin
            chk("refill_port", 128'(bus.refill_port_o), 128'(p));
            chk("refill_addr", 128'(bus.refill_addr_o), 128'({ea[31:4], 4'b0}));
            chk("refill_data", bus.refill_data_o,       128'(d));
        end
        bus.req_valid_i[p] = 1'b0;
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [1:0] s, input logic u);
        bus.req_paddr_i[p]    = a;
        bus.req_size_i[p]     = s;
        bus.req_uncached_i[p] = u;
        bus.req_valid_i[p]    = 1'b1;
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.req_valid_i    = '0;
        bus.req_paddr_i    = '0;
        bus.req_size_i     = '0;
        bus.req_uncached_i = '0;
        bus.ar_ready_i     = 1'b0;
        bus.r_valid_i      = 1'b0;
        bus.r_data_i       = '0;
        bus.r_last_i       = 1'b0;
        bus.r_resp_i       = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Port 0 refill, zero-wait bus: AR in cycle 1, ready pulse in cycle 6
        bus.ar_ready_i = 1'b1;
        set_req(0, 32'h1C00_0008, 2'd3, 1'b0);
        @(negedge clk);
        txn(0, 32'h1C00_0000, 8'd3, 4, {32'h44, 32'h33, 32'h22, 32'h11}, -1,
            64'h00000044_00000033, 1'b1);
        @(negedge clk);
        chk("ready_one_cycle", 128'(bus.req_ready_o), 128'(0));
        chk("refill_one_cycle", 128'(bus.refill_valid_o), 128'(0));

        // Both ports valid straight out of reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_req(0, 32'h1C00_0044, 2'd3, 1'b1);
        set_req(1, 32'hBFD0_0004, 2'd2, 1'b1);
        @(negedge clk);
`ifdef WIRED_ARB_FIXED_PRIO_EN
        txn(1, 32'hBFD0_0004, 8'd0, 1, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, -1,
            64'hDEADBEEF_00000000, 1'b0);
        @(negedge clk);
        chk("idle_gap_ar_valid", 128'(bus.ar_valid_o), 128'(0));
        @(negedge clk);
        txn(0, 32'h1C00_0040, 8'd1, 2, {32'h0, 32'h0, 32'h66, 32'h55}, -1,
            64'h00000066_00000055, 1'b0);
`else
        txn(0, 32'h1C00_0040, 8'd1, 2, {32'h0, 32'h0, 32'h66, 32'h55}, -1,
            64'h00000066_00000055, 1'b0);
        @(negedge clk);
        chk("idle_gap_ar_valid", 128'(bus.ar_valid_o), 128'(0));
        @(negedge clk);
        txn(1, 32'hBFD0_0004, 8'd0, 1, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, -1,
            64'hDEADBEEF_00000000, 1'b0);
`endif

        // Refill with SLVERR on beat 2: error reported, no line write
        @(negedge clk);
        set_req(0, 32'h0000_0100, 2'd3, 1'b0);
        @(negedge clk);
        txn(0, 32'h0000_0100, 8'd3, 4, {32'h4, 32'h3, 32'h2, 32'h1}, 2,
            64'h00000002_00000001, 1'b0);

        // AR back-pressure for 5 cycles: fields stable, no r_ready yet
        @(negedge clk);
        bus.ar_ready_i = 1'b0;
        set_req(1, 32'h8000_1238, 2'd2, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall_ar_valid", 128'(bus.ar_valid_o), 128'(1));
            chk("stall_ar_addr",  128'(bus.ar_addr_o),  128'(32'h8000_1230));
            chk("stall_ar_len",   128'(bus.ar_len_o),   128'(8'd3));
            chk("stall_r_ready",  128'(bus.r_ready_o),  128'(0));
            @(negedge clk);
        end
        bus.ar_ready_i = 1'b1;
        txn(1, 32'h8000_1230, 8'd3, 4, {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001},
            -1, 64'hDDDD0004_CCCC0003, 1'b1);

        // Asynchronous reset in S_R, then clean restart
        @(negedge clk);
        set_req(0, 32'h0000_2000, 2'd3, 1'b0);
        @(negedge clk);
        chk("pre_rst_ar_valid", 128'(bus.ar_valid_o), 128'(1));
        @(negedge clk);
        bus.r_valid_i = 1'b1;
        bus.r_data_i  = 32'h77;
        @(negedge clk);
        bus.r_data_i  = 32'h78;
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("async_rst");
        bus.r_valid_i   = 1'b0;
        bus.req_valid_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("post_rst");
        set_req(1, 32'h0000_3008, 2'd3, 1'b1);
        @(negedge clk);
        wait_ar(10);
        txn(1, 32'h0000_3008, 8'd1, 2, {32'h0, 32'h0, 32'hA, 32'h9}, -1,
            64'h0000000A_00000009, 1'b0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
